// File: rtl/acc_cpu_pkg.sv
// rtl/acc_cpu_pkg.sv - shared types and codes for the accumulator CPU sequencer
//
// Purpose: sequencer state enum, opcode map, ALU function codes and MAR
// source encodings used by acc_cpu_sequencer and acc_cpu_decode.
// No ports (package).

package acc_cpu_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_F_ADDR  = 4'd1,
    ST_F_READ  = 4'd2,
    ST_F_MBR   = 4'd3,
    ST_F_IR    = 4'd4,
    ST_DECODE  = 4'd5,
    ST_O_ADDR  = 4'd6,
    ST_O_READ  = 4'd7,
    ST_O_MBR   = 4'd8,
    ST_EXEC    = 4'd9,
    ST_S_WRITE = 4'd10,
    ST_HALTED  = 4'd11
  } state_t;

  localparam logic [3:0] OP_NOP      = 4'h0;
  localparam logic [3:0] OP_LOAD     = 4'h1;
  localparam logic [3:0] OP_STORE    = 4'h2;
  localparam logic [3:0] OP_ADD      = 4'h3;
  localparam logic [3:0] OP_SUB      = 4'h4;
  localparam logic [3:0] OP_AND      = 4'h5;
  localparam logic [3:0] OP_OR       = 4'h6;
  localparam logic [3:0] OP_HALT     = 4'h7;
  localparam logic [3:0] OP_SKIPCOND = 4'h8;
  localparam logic [3:0] OP_JUMP     = 4'h9;
  localparam logic [3:0] OP_CLEAR    = 4'hA;
  localparam logic [3:0] OP_ADDI     = 4'hB;
  localparam logic [3:0] OP_JUMPI    = 4'hC;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b1000;
  localparam logic [3:0] ALU_OR  = 4'b1001;

  localparam logic [1:0] MAR_SRC_PC  = 2'd0;
  localparam logic [1:0] MAR_SRC_IR  = 2'd1;
  localparam logic [1:0] MAR_SRC_MBR = 2'd2;

endpackage

// File: rtl/acc_cpu_decode.sv
// rtl/acc_cpu_decode.sv - opcode to instruction-class decoder
//
// Purpose: purely combinational classification of the IR opcode.
// Ports:
//   i_opcode   in  4  IR[15:12]
//   o_nop      out 1  retires straight from DECODE
//   o_operand  out 1  needs an operand read before EXEC
//   o_indirect out 1  needs a second, pointer-based operand read
//   o_store    out 1  operand address then memory write
//   o_direct   out 1  goes straight from DECODE to EXEC
//   o_halt     out 1  halts the sequencer
//   o_illegal  out 1  opcode D-F
//   o_alu_op   out 1  EXEC loads the ALU result into the accumulator
//   o_alu_sel  out 4  ALU function for o_alu_op instructions, else ADD (0000)

module acc_cpu_decode
  import acc_cpu_pkg::*;
(
  input  logic [3:0] i_opcode,
  output logic       o_nop,
  output logic       o_operand,
  output logic       o_indirect,
  output logic       o_store,
  output logic       o_direct,
  output logic       o_halt,
  output logic       o_illegal,
  output logic       o_alu_op,
  output logic [3:0] o_alu_sel
);

  always_comb begin
    o_nop      = 1'b0;
    o_operand  = 1'b0;
    o_indirect = 1'b0;
    o_store    = 1'b0;
    o_direct   = 1'b0;
    o_halt     = 1'b0;
    o_illegal  = 1'b0;
    o_alu_op   = 1'b0;
    o_alu_sel  = ALU_ADD;
    case (i_opcode)
      OP_NOP:      o_nop = 1'b1;
      OP_LOAD:     o_operand = 1'b1;
      OP_STORE:    o_store = 1'b1;
      OP_ADD: begin
        o_operand = 1'b1;
        o_alu_op  = 1'b1;
        o_alu_sel = ALU_ADD;
      end
      OP_SUB: begin
        o_operand = 1'b1;
        o_alu_op  = 1'b1;
        o_alu_sel = ALU_SUB;
      end
      OP_AND: begin
        o_operand = 1'b1;
        o_alu_op  = 1'b1;
        o_alu_sel = ALU_AND;
      end
      OP_OR: begin
        o_operand = 1'b1;
        o_alu_op  = 1'b1;
        o_alu_sel = ALU_OR;
      end
      OP_HALT:     o_halt = 1'b1;
      OP_SKIPCOND: o_direct = 1'b1;
      OP_JUMP:     o_direct = 1'b1;
      OP_CLEAR:    o_direct = 1'b1;
      OP_ADDI: begin
        o_operand  = 1'b1;
        o_indirect = 1'b1;
        o_alu_op   = 1'b1;
        o_alu_sel  = ALU_ADD;
      end
      OP_JUMPI:    o_operand = 1'b1;
      default:     o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/acc_cpu_sequencer.sv
// rtl/acc_cpu_sequencer.sv - fetch/decode/execute control FSM for the accumulator CPU
//
// Purpose: drives every datapath strobe, mux select, ALU code and memory
// write enable; counts retired instructions.
// Optional feature macro: ILLEGAL_TRAP_EN (opcodes D-F trap to HALTED and
// raise the extra output 'illegal'; otherwise they behave as NOP).
// Ports:
//   clk, reset_n           clock (rising edge), asynchronous active-low reset
//   start                  begin/resume; sampled only in IDLE and HALTED
//   instr[15:0]            IR contents; acc_zero / acc_neg accumulator status
//   mar_load, mar_src[1:0] MAR capture and source (PC / IR[11:0] / MBR)
//   mbr_load, ir_load      MBR and IR capture
//   pc_inc, pc_load,pc_src PC increment, jump load and jump source
//   acc_load, acc_src      accumulator load from ALU (0) or MBR (1)
//   acc_clear, alu_sel     accumulator clear, ALU function code
//   mem_we                 write accumulator to memory at MAR
//   busy, halted           status
//   instr_count[CNT_W-1:0] retired-instruction count (wraps)
//   illegal                (ILLEGAL_TRAP_EN only) trapped on opcode D-F

module acc_cpu_sequencer
  import acc_cpu_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [15:0]      instr,
  input  logic             acc_zero,
  input  logic             acc_neg,
  output logic             mar_load,
  output logic [1:0]       mar_src,
  output logic             mbr_load,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             pc_src,
  output logic             acc_load,
  output logic             acc_src,
  output logic             acc_clear,
  output logic [3:0]       alu_sel,
  output logic             mem_we,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic             illegal
`endif
);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_ind_pass;      // second (pointer) pass of an ADDI operand read
  logic             w_ind_pass_next;
  logic             w_retire;
  logic [CNT_W-1:0] r_instr_count;

  logic [3:0] w_opcode;
  logic [1:0] w_cond;
  logic       w_skip;
  logic       w_nop, w_operand, w_indirect, w_store, w_direct;
  logic       w_halt, w_illegal, w_alu_op;
  logic [3:0] w_alu_sel;
  logic       w_unused_instr;

  assign w_opcode       = instr[ADDR_W+3:ADDR_W];
  assign w_cond         = instr[ADDR_W-1:ADDR_W-2];
  assign w_unused_instr = |instr[ADDR_W-3:0];

  acc_cpu_decode u_decode (
    .i_opcode   (w_opcode),
    .o_nop      (w_nop),
    .o_operand  (w_operand),
    .o_indirect (w_indirect),
    .o_store    (w_store),
    .o_direct   (w_direct),
    .o_halt     (w_halt),
    .o_illegal  (w_illegal),
    .o_alu_op   (w_alu_op),
    .o_alu_sel  (w_alu_sel)
  );

  always_comb begin
    case (w_cond)
      2'b00:   w_skip = acc_neg;
      2'b01:   w_skip = acc_zero;
      2'b10:   w_skip = !acc_neg && !acc_zero;
      default: w_skip = 1'b0;
    endcase
  end

`ifdef ILLEGAL_TRAP_EN
  logic w_trap;
  logic r_illegal;
`endif

  // Next-state, indirect-pass and retire decode.
  always_comb begin
    w_next_state    = r_state;
    w_ind_pass_next = r_ind_pass;
    w_retire        = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    w_trap          = 1'b0;
`endif
    case (r_state)
      ST_IDLE, ST_HALTED: if (start) w_next_state = ST_F_ADDR;
      ST_F_ADDR: w_next_state = ST_F_READ;
      ST_F_READ: w_next_state = ST_F_MBR;
      ST_F_MBR:  w_next_state = ST_F_IR;
      ST_F_IR:   w_next_state = ST_DECODE;
      ST_DECODE: begin
        w_ind_pass_next = 1'b0;
        if (w_halt) begin
          w_next_state = ST_HALTED;
          w_retire     = 1'b1;
        end else if (w_illegal) begin
`ifdef ILLEGAL_TRAP_EN
          w_next_state = ST_HALTED;
          w_trap       = 1'b1;
`else
          w_next_state = ST_F_ADDR;
          w_retire     = 1'b1;
`endif
        end else if (w_nop) begin
          w_next_state = ST_F_ADDR;
          w_retire     = 1'b1;
        end else if (w_direct) begin
          w_next_state = ST_EXEC;
        end else begin
          w_next_state = ST_O_ADDR;
        end
      end
      ST_O_ADDR: w_next_state = w_store ? ST_S_WRITE : ST_O_READ;
      ST_O_READ: w_next_state = ST_O_MBR;
      ST_O_MBR: begin
        if (w_indirect && !r_ind_pass) begin
          w_next_state    = ST_O_ADDR;
          w_ind_pass_next = 1'b1;
        end else begin
          w_next_state = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_next_state    = ST_F_ADDR;
        w_ind_pass_next = 1'b0;
        w_retire        = 1'b1;
      end
      ST_S_WRITE: begin
        w_next_state = ST_F_ADDR;
        w_retire     = 1'b1;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_ind_pass    <= 1'b0;
      r_instr_count <= '0;
    end else begin
      r_state    <= w_next_state;
      r_ind_pass <= w_ind_pass_next;
      if (w_retire) r_instr_count <= r_instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_illegal <= 1'b0;
    end else if ((r_state == ST_IDLE || r_state == ST_HALTED) && start) begin
      r_illegal <= 1'b0;
    end else if (w_trap) begin
      r_illegal <= 1'b1;
    end
  end

  assign illegal = r_illegal;
`endif

  // Outputs come from the state register only (plus IR and status for EXEC),
  // so everything drops as soon as reset forces IDLE.
  always_comb begin
    mar_load  = 1'b0;
    mar_src   = MAR_SRC_PC;
    mbr_load  = 1'b0;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    pc_src    = 1'b0;
    acc_load  = 1'b0;
    acc_src   = 1'b0;
    acc_clear = 1'b0;
    alu_sel   = ALU_ADD;
    mem_we    = 1'b0;
    case (r_state)
      ST_F_ADDR: begin
        mar_load = 1'b1;
        mar_src  = MAR_SRC_PC;
      end
      ST_F_MBR, ST_O_MBR: mbr_load = 1'b1;
      ST_F_IR: begin
        ir_load = 1'b1;
        pc_inc  = 1'b1;
      end
      ST_O_ADDR: begin
        mar_load = 1'b1;
        mar_src  = r_ind_pass ? MAR_SRC_MBR : MAR_SRC_IR;
      end
      ST_S_WRITE: mem_we = 1'b1;
      ST_EXEC: begin
        if (w_alu_op) begin
          acc_load = 1'b1;
          alu_sel  = w_alu_sel;
        end
        case (w_opcode)
          OP_LOAD: begin
            acc_load = 1'b1;
            acc_src  = 1'b1;
          end
          OP_SKIPCOND: pc_inc = w_skip;
          OP_JUMP:     pc_load = 1'b1;
          OP_JUMPI: begin
            pc_load = 1'b1;
            pc_src  = 1'b1;
          end
          OP_CLEAR:    acc_clear = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign busy        = (r_state != ST_IDLE) && (r_state != ST_HALTED);
  assign halted      = (r_state == ST_HALTED);
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_acc_cpu_sequencer.sv
// tb/tb_acc_cpu_sequencer.sv - self-checking bench for acc_cpu_sequencer

module tb_acc_cpu_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, start;
  logic        mar_load, mbr_load, ir_load, pc_inc, pc_load, pc_src;
  logic        acc_load, acc_src, acc_clear, mem_we, busy, halted;
  logic [1:0]  mar_src;
  logic [3:0]  alu_sel;
  logic [15:0] instr_count;
`ifdef ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  // Datapath and memory surrounding the sequencer.
  logic [15:0] pc, mar, mbr, ir, acc, mem_dout;
  logic [15:0] mem [0:16383];
  logic        ld_we, dp_set;
  logic [13:0] ld_addr;
  logic [15:0] ld_data, set_pc, set_acc;

  acc_cpu_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .instr(ir),
    .acc_zero(acc == 16'h0), .acc_neg(acc[15]),
    .mar_load(mar_load), .mar_src(mar_src), .mbr_load(mbr_load), .ir_load(ir_load),
    .pc_inc(pc_inc), .pc_load(pc_load), .pc_src(pc_src), .acc_load(acc_load),
    .acc_src(acc_src), .acc_clear(acc_clear), .alu_sel(alu_sel), .mem_we(mem_we),
    .busy(busy), .halted(halted), .instr_count(instr_count)
`ifdef ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  // Narrow-counter instance fed a constant NOP, used for the wrap check.
  logic        wrap_rst_n, wrap_start;
  logic        wr_mar_load, wr_mbr_load, wr_ir_load, wr_pc_inc, wr_pc_load, wr_pc_src;
  logic        wr_acc_load, wr_acc_src, wr_acc_clear, wr_mem_we, wr_busy, wr_halted;
  logic [1:0]  wr_mar_src;
  logic [3:0]  wr_alu_sel;
  logic [2:0]  wr_count;
`ifdef ILLEGAL_TRAP_EN
  logic        wr_illegal;
`endif

  acc_cpu_sequencer #(.ADDR_W(12), .CNT_W(3)) u_wrap (
    .clk(clk), .reset_n(wrap_rst_n), .start(wrap_start), .instr(16'h0000),
    .acc_zero(1'b1), .acc_neg(1'b0),
    .mar_load(wr_mar_load), .mar_src(wr_mar_src), .mbr_load(wr_mbr_load), .ir_load(wr_ir_load),
    .pc_inc(wr_pc_inc), .pc_load(wr_pc_load), .pc_src(wr_pc_src), .acc_load(wr_acc_load),
    .acc_src(wr_acc_src), .acc_clear(wr_acc_clear), .alu_sel(wr_alu_sel), .mem_we(wr_mem_we),
    .busy(wr_busy), .halted(wr_halted), .instr_count(wr_count)
`ifdef ILLEGAL_TRAP_EN
    , .illegal(wr_illegal)
`endif
  );

  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] s);
    case (s)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b1000: return a & b;
      4'b1001: return a | b;
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) begin
    mem_dout <= mem[mar[13:0]];
    if (ld_we) mem[ld_addr] <= ld_data;
    else if (mem_we) mem[mar[13:0]] <= acc;
    if (dp_set) begin
      pc  <= set_pc;
      acc <= set_acc;
    end else begin
      if (mar_load)
        mar <= (mar_src == 2'd0) ? pc : (mar_src == 2'd1) ? {4'h0, ir[11:0]} : mbr;
      if (mbr_load) mbr <= mem_dout;
      if (ir_load) ir <= mbr;
      if (pc_load) pc <= pc_src ? mbr : {4'h0, ir[11:0]};
      else if (pc_inc) pc <= pc + 16'd1;
      if (acc_clear) acc <= 16'h0;
      else if (acc_load) acc <= acc_src ? mbr : alu_f(acc, mbr, alu_sel);
    end
  end

  int src2_cnt = 0;
  always @(negedge clk) if (mar_load && mar_src == 2'd2) src2_cnt <= src2_cnt + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mem_wr(input logic [13:0] a, input logic [15:0] d);
    @(negedge clk);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_we = 1'b0;
  endtask

  task automatic set_dp(input logic [15:0] p, input logic [15:0] a);
    @(negedge clk);
    dp_set = 1'b1; set_pc = p; set_acc = a;
    @(posedge clk); #1;
    dp_set = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
  endtask

  // Pulse start and count clock edges until HALTED is entered.
  task automatic run(input bit noise, output int cyc);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 0;
    while (!halted && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (noise) start = halted ? 1'b0 : ($urandom_range(0, 1) == 1);
    end
    start = 1'b0;
    chk("halt_reached", {31'b0, halted}, 32'd1);
  endtask

  // Instruction-level reference: executes the program from rm[] and sums
  // the per-instruction latencies.
  logic [15:0] rm [0:511];

  task automatic model(input logic [15:0] a0, output logic [15:0] ea, output logic [15:0] ep,
                       output int ecyc, output int ecnt);
    logic [15:0] w, a, pcm, accm;
    bit stop;
    pcm = 0; accm = a0; ecyc = 0; ecnt = 0; stop = 0;
    for (int s = 0; s < 40 && !stop; s++) begin
      w = rm[pcm[8:0]];
      pcm = pcm + 1;
      a = {4'h0, w[11:0]};
      ecnt++;
      case (w[15:12])
        4'h0: ecyc += 5;
        4'h1: begin accm = rm[a[8:0]]; ecyc += 9; end
        4'h2: begin rm[a[8:0]] = accm; ecyc += 7; end
        4'h3: begin accm = accm + rm[a[8:0]]; ecyc += 9; end
        4'h4: begin accm = accm - rm[a[8:0]]; ecyc += 9; end
        4'h5: begin accm = accm & rm[a[8:0]]; ecyc += 9; end
        4'h6: begin accm = accm | rm[a[8:0]]; ecyc += 9; end
        4'h7: begin ecyc += 5; stop = 1; end
        4'h8: begin
          ecyc += 6;
          if ((w[11:10] == 2'b00 && accm[15]) || (w[11:10] == 2'b01 && accm == 0) ||
              (w[11:10] == 2'b10 && !accm[15] && accm != 0)) pcm = pcm + 1;
        end
        4'h9: begin pcm = a; ecyc += 6; end
        4'hA: begin accm = 0; ecyc += 6; end
        4'hB: begin accm = accm + rm[rm[a[8:0]][8:0]]; ecyc += 12; end
        default: begin pcm = rm[a[8:0]]; ecyc += 9; end
      endcase
    end
    ea = accm; ep = pcm;
  endtask

  typedef struct {
    logic [15:0] instr, acc0, m10, exp_acc, exp_pc, exp_m12;
    int          exp_cyc, exp_cnt, exp_src2;
    logic        exp_ill;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] i, input logic [15:0] a0, input logic [15:0] m,
                              input logic [15:0] ea, input logic [15:0] ep, input int ec,
                              input int en, input logic [15:0] e12, input int s2, input logic il);
    vec_t v;
    v.instr = i; v.acc0 = a0; v.m10 = m; v.exp_acc = ea; v.exp_pc = ep; v.exp_cyc = ec;
    v.exp_cnt = en; v.exp_m12 = e12; v.exp_src2 = s2; v.exp_ill = il;
    return v;
  endfunction

  vec_t vt [20];

  initial begin
    int cyc, n, s0, ecyc, ecnt;
    logic [15:0] ea, ep, w, dv, acc0;

    reset_n = 1'b0; start = 1'b0; ld_we = 1'b0; dp_set = 1'b0;
    ld_addr = '0; ld_data = '0; set_pc = '0; set_acc = '0;
    wrap_rst_n = 1'b0; wrap_start = 1'b0;
    #12;
    chk("reset_busy", {31'b0, busy}, 0);
    chk("reset_halted", {31'b0, halted}, 0);
    chk("reset_count", {16'b0, instr_count}, 0);
    chk("reset_mar_load", {31'b0, mar_load}, 0);
    @(negedge clk); reset_n = 1'b1;

    // Counter wrap on the 3-bit instance: one NOP retires every 5 cycles.
    @(negedge clk); wrap_rst_n = 1'b1;
    @(negedge clk); wrap_start = 1'b1;
    @(posedge clk); #1; wrap_start = 1'b0;
    repeat (35) @(posedge clk);
    #1 chk("wrap_pre", {29'b0, wr_count}, 7);
    repeat (5) @(posedge clk);
    #1 chk("wrap_zero", {29'b0, wr_count}, 0);
    chk("wrap_busy", {31'b0, wr_busy}, 1);
    wrap_rst_n = 1'b0;

    // Single-instruction vectors: instr at 0, HALTs at 1..4.
    vt[0]  = mk(16'h0000, 16'h0005, 16'h0000, 16'h0005, 16'd2, 10, 2, 16'h0000, 0, 1'b0);
    vt[1]  = mk(16'h1010, 16'h0000, 16'h1234, 16'h1234, 16'd2, 14, 2, 16'h0000, 0, 1'b0);
    vt[2]  = mk(16'h2012, 16'hBEEF, 16'h0000, 16'hBEEF, 16'd2, 12, 2, 16'hBEEF, 0, 1'b0);
    vt[3]  = mk(16'h3010, 16'h0005, 16'h0007, 16'h000C, 16'd2, 14, 2, 16'h0000, 0, 1'b0);
    vt[4]  = mk(16'h4010, 16'h0005, 16'h0007, 16'hFFFE, 16'd2, 14, 2, 16'h0000, 0, 1'b0);
    vt[5]  = mk(16'h5010, 16'h0FF0, 16'h3C3C, 16'h0C30, 16'd2, 14, 2, 16'h0000, 0, 1'b0);
    vt[6]  = mk(16'h6010, 16'h0F00, 16'h00F0, 16'h0FF0, 16'd2, 14, 2, 16'h0000, 0, 1'b0);
    vt[7]  = mk(16'h8400, 16'h0000, 16'h0000, 16'h0000, 16'd3, 11, 2, 16'h0000, 0, 1'b0);
    vt[8]  = mk(16'h8400, 16'h0003, 16'h0000, 16'h0003, 16'd2, 11, 2, 16'h0000, 0, 1'b0);
    vt[9]  = mk(16'h8000, 16'h8000, 16'h0000, 16'h8000, 16'd3, 11, 2, 16'h0000, 0, 1'b0);
    vt[10] = mk(16'h8000, 16'h0001, 16'h0000, 16'h0001, 16'd2, 11, 2, 16'h0000, 0, 1'b0);
    vt[11] = mk(16'h8800, 16'h0001, 16'h0000, 16'h0001, 16'd3, 11, 2, 16'h0000, 0, 1'b0);
    vt[12] = mk(16'h8800, 16'h0000, 16'h0000, 16'h0000, 16'd2, 11, 2, 16'h0000, 0, 1'b0);
    vt[13] = mk(16'h8C00, 16'h8000, 16'h0000, 16'h8000, 16'd2, 11, 2, 16'h0000, 0, 1'b0);
    vt[14] = mk(16'h9003, 16'h0000, 16'h0000, 16'h0000, 16'd4, 11, 2, 16'h0000, 0, 1'b0);
    vt[15] = mk(16'hA000, 16'h0055, 16'h0000, 16'h0000, 16'd2, 11, 2, 16'h0000, 0, 1'b0);
    vt[16] = mk(16'hB020, 16'h0001, 16'h0000, 16'h000A, 16'd2, 17, 2, 16'h0000, 1, 1'b0);
    vt[17] = mk(16'hC010, 16'h0000, 16'h0004, 16'h0000, 16'd5, 14, 2, 16'h0000, 0, 1'b0);
    vt[18] = mk(16'h7000, 16'h0003, 16'h0000, 16'h0003, 16'd1, 5, 1, 16'h0000, 0, 1'b0);
`ifdef ILLEGAL_TRAP_EN
    vt[19] = mk(16'hE000, 16'h0003, 16'h0000, 16'h0003, 16'd1, 5, 0, 16'h0000, 0, 1'b1);
`else
    vt[19] = mk(16'hE000, 16'h0003, 16'h0000, 16'h0003, 16'd2, 10, 2, 16'h0000, 0, 1'b0);
`endif

    for (int v = 0; v < 20; v++) begin
      do_reset();
      mem_wr(0, vt[v].instr);
      for (int k = 1; k < 5; k++) mem_wr(14'(k), 16'h7000);
      mem_wr(14'h010, vt[v].m10);
      mem_wr(14'h012, 16'h0000);
      mem_wr(14'h020, 16'h0030);
      mem_wr(14'h030, 16'h0009);
      set_dp(16'h0000, vt[v].acc0);
      s0 = src2_cnt;
      run(1'b0, cyc);
      chk($sformatf("v%0d_cycles", v), cyc, vt[v].exp_cyc);
      chk($sformatf("v%0d_acc", v), {16'b0, acc}, {16'b0, vt[v].exp_acc});
      chk($sformatf("v%0d_pc", v), {16'b0, pc}, {16'b0, vt[v].exp_pc});
      chk($sformatf("v%0d_count", v), {16'b0, instr_count}, vt[v].exp_cnt);
      chk($sformatf("v%0d_m12", v), {16'b0, mem[14'h012]}, {16'b0, vt[v].exp_m12});
      chk($sformatf("v%0d_src2", v), src2_cnt - s0, vt[v].exp_src2);
`ifdef ILLEGAL_TRAP_EN
      chk($sformatf("v%0d_illegal", v), {31'b0, illegal}, {31'b0, vt[v].exp_ill});
`endif
    end

`ifdef ILLEGAL_TRAP_EN
    // Restart after a trap clears illegal and resumes at the next word.
    do_reset();
    mem_wr(0, 16'hE000);
    mem_wr(1, 16'h7000);
    set_dp(16'h0000, 16'h0000);
    run(1'b0, cyc);
    chk("trap_illegal", {31'b0, illegal}, 1);
    run(1'b0, cyc);
    chk("trap_cleared", {31'b0, illegal}, 0);
    chk("trap_resume_count", {16'b0, instr_count}, 1);
`endif

    // Reset while mem_we is high.
    do_reset();
    mem_wr(0, 16'h0000);
    mem_wr(1, 16'h2012);
    mem_wr(14'h012, 16'h0000);
    set_dp(16'h0000, 16'hABCD);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n = 0;
    while (!mem_we && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("swrite_reached", {31'b0, mem_we}, 1);
    chk("swrite_count", {16'b0, instr_count}, 1);
    reset_n = 1'b0;
    #1;
    chk("rst_mem_we", {31'b0, mem_we}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_halted", {31'b0, halted}, 0);
    chk("rst_count", {16'b0, instr_count}, 0);
    @(negedge clk); @(negedge clk); reset_n = 1'b1;
    chk("rst_no_write", {16'b0, mem[14'h012]}, 0);

    // Four-instruction program, start noise while busy, then resume after HALT.
    do_reset();
    mem_wr(0, 16'h1010); mem_wr(1, 16'h3011); mem_wr(2, 16'h2012); mem_wr(3, 16'h7000);
    mem_wr(4, 16'hA000); mem_wr(5, 16'h7000);
    mem_wr(14'h010, 16'd5); mem_wr(14'h011, 16'd7); mem_wr(14'h012, 16'd0);
    set_dp(16'h0000, 16'h0000);
    run(1'b1, cyc);
    chk("prog_cycles", cyc, 30);
    chk("prog_m12", {16'b0, mem[14'h012]}, 12);
    chk("prog_count", {16'b0, instr_count}, 4);
    chk("prog_pc", {16'b0, pc}, 4);
    run(1'b0, cyc);
    chk("resume_cycles", cyc, 11);
    chk("resume_acc", {16'b0, acc}, 0);
    chk("resume_count", {16'b0, instr_count}, 6);
    chk("resume_pc", {16'b0, pc}, 6);

    // Random straight-line programs against the instruction-level model.
    for (int t = 0; t < 25; t++) begin
      do_reset();
      for (int i = 0; i < 16; i++) begin
        dv = 16'($urandom);
        rm[256 + i] = dv;
        mem_wr(14'(256 + i), dv);
      end
      for (int i = 0; i < 4; i++) begin
        dv = 16'h0100 + 16'($urandom_range(0, 15));
        rm[272 + i] = dv;
        mem_wr(14'(272 + i), dv);
      end
      for (int p = 0; p < 12; p++) begin
        if (p >= 8) w = 16'h7000;
        else begin
          case ($urandom_range(0, 10))
            0:  w = 16'h0000;
            1:  w = 16'h1100 + 16'($urandom_range(0, 15));
            2:  w = 16'h2100 + 16'($urandom_range(0, 15));
            3:  w = 16'h3100 + 16'($urandom_range(0, 15));
            4:  w = 16'h4100 + 16'($urandom_range(0, 15));
            5:  w = 16'h5100 + 16'($urandom_range(0, 15));
            6:  w = 16'h6100 + 16'($urandom_range(0, 15));
            7:  w = 16'h8000 | 16'($urandom_range(0, 3) << 10);
            8:  w = 16'h9000 + 16'(p + 1 + $urandom_range(0, 2));
            9:  w = 16'hA000;
            default: w = 16'hB110 + 16'($urandom_range(0, 3));
          endcase
        end
        rm[p] = w;
        mem_wr(14'(p), w);
      end
      acc0 = 16'($urandom);
      set_dp(16'h0000, acc0);
      model(acc0, ea, ep, ecyc, ecnt);
      run(1'b1, cyc);
      chk($sformatf("r%0d_cycles", t), cyc, ecyc);
      chk($sformatf("r%0d_acc", t), {16'b0, acc}, {16'b0, ea});
      chk($sformatf("r%0d_pc", t), {16'b0, pc}, {16'b0, ep});
      chk($sformatf("r%0d_count", t), {16'b0, instr_count}, ecnt);
      for (int i = 0; i < 16; i++)
        chk($sformatf("r%0d_mem%0d", t, i), {16'b0, mem[14'(256 + i)]}, {16'b0, rm[256 + i]});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
